// File: rtl/fft_stage_controller_if.sv
// fft_stage_controller_if: handshake/bus bundle between an FFT pass requester and the stage sequencer.
//   start            requester -> controller: begin one full pass (sampled in IDLE only)
//   stall            requester -> controller: freeze butterfly issue (FFT_STALL_EN builds only)
//   stage_count_out  controller -> user: current stage, feeds twiddle_index
//   bfly_count       controller -> user: butterfly index within the stage
//   bfly_en          controller -> user: butterfly issued this cycle, addr_a/addr_b valid
//   addr_a, addr_b   controller -> user: top/bottom operand sample-RAM addresses
//   busy, done       controller -> user: pass in progress / one-cycle end-of-pass pulse
// Optional feature macro: FFT_STALL_EN adds the stall signal.
interface fft_stage_controller_if #(
    parameter int LOG2N = 3
);
    logic             start;
`ifdef FFT_STALL_EN
    logic             stall;
`endif
    logic [LOG2N-1:0] stage_count_out;
    logic [LOG2N-2:0] bfly_count;
    logic             bfly_en;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic             busy;
    logic             done;

`ifdef FFT_STALL_EN
    modport master (
        output start, stall,
        input  stage_count_out, bfly_count, bfly_en, addr_a, addr_b, busy, done
    );
    modport slave (
        input  start, stall,
        output stage_count_out, bfly_count, bfly_en, addr_a, addr_b, busy, done
    );
`else
    modport master (
        output start,
        input  stage_count_out, bfly_count, bfly_en, addr_a, addr_b, busy, done
    );
    modport slave (
        input  start,
        output stage_count_out, bfly_count, bfly_en, addr_a, addr_b, busy, done
    );
`endif
endinterface

// File: rtl/fft_stage_controller.sv
// fft_stage_controller: sequencing FSM for a radix-2 DIT FFT core.
//   Walks all LOG2N stages, issuing one butterfly per cycle with its operand
//   address pair, then idles BFLY_LAT drain cycles so the butterfly pipeline
//   clears before the next stage reads its results.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset
//   bus  fft_stage_controller_if.slave: start/stall in; stage_count_out,
//        bfly_count, bfly_en, addr_a, addr_b, busy, done out (all registered)
// Optional feature macro: FFT_STALL_EN enables the stall input.
module fft_stage_controller #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3,
    parameter int BFLY_LAT = 2
) (
    input logic                   clk,
    input logic                   rst,
    fft_stage_controller_if.slave bus
);
    localparam int HALF = N_POINTS / 2;
    localparam int BW   = LOG2N - 1;
    localparam int DW   = (BFLY_LAT > 2) ? $clog2(BFLY_LAT) : 1;
    localparam logic [BW-1:0]    LAST_BFLY  = BW'(HALF - 1);
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [BW-1:0]    bfly_q, bfly_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic             bfly_en_q, bfly_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stall_w;
    logic             issued, last_bfly, last_stage, drain_end, stage_end, next_stage;

`ifdef FFT_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    // Top operand: insert a zero bit at position s of k; the bottom operand sets that bit.
    function automatic logic [LOG2N-1:0] pair_a(input logic [LOG2N-1:0] s, input logic [BW-1:0] k);
        logic [LOG2N-1:0] kk;
        kk = {1'b0, k};
        return ((kk >> s) << (s + 1'b1)) | (kk & ((LOG2N'(1) << s) - 1'b1));
    endfunction

    // A butterfly only counts as issued when bfly_en was actually high; a stalled
    // ISSUE cycle leaves the pending butterfly on the address lines un-issued.
    assign issued     = (state_q == ISSUE) && bfly_en_q;
    assign last_bfly  = bfly_q == LAST_BFLY;
    assign last_stage = stage_q == LAST_STAGE;
    assign drain_end  = drain_q == DW'(BFLY_LAT - 1);
    assign stage_end  = issued && last_bfly;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? ISSUE : IDLE;
            ISSUE:   if (stage_end) state_d = (BFLY_LAT != 0) ? DRAIN : last_stage ? DONE : ISSUE;
            DRAIN:   if (drain_end) state_d = last_stage ? DONE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition being taken.
    assign next_stage = (state_d == ISSUE) && ((state_q == DRAIN) || stage_end);

    always_comb begin
        stage_d   = (state_q == DONE) ? '0 : next_stage ? stage_q + 1'b1 : stage_q;
        bfly_d    = ((state_q == DONE) || next_stage) ? '0 :
                    (issued && !last_bfly) ? bfly_q + 1'b1 : bfly_q;
        drain_d   = ((state_q == DRAIN) && !drain_end) ? drain_q + 1'b1 : '0;
        // Stall only suppresses a butterfly that would follow another ISSUE cycle.
        bfly_en_d = (state_d == ISSUE) && !((state_q == ISSUE) && stall_w);
        addr_a_d  = (state_d == ISSUE) ? pair_a(stage_d, bfly_d) : addr_a_q;
        addr_b_d  = (state_d == ISSUE) ? addr_a_d | (LOG2N'(1) << stage_d) : addr_b_q;
        busy_d    = (state_d == ISSUE) || (state_d == DRAIN);
        done_d    = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q   <= '0;
            bfly_q    <= '0;
            drain_q   <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            bfly_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            bfly_q    <= bfly_d;
            drain_q   <= drain_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            bfly_en_q <= bfly_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.stage_count_out = stage_q;
    assign bus.bfly_count      = bfly_q;
    assign bus.bfly_en         = bfly_en_q;
    assign bus.addr_a          = addr_a_q;
    assign bus.addr_b          = addr_b_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

    // Structural invariants of the sequencer.
    assert property (@(posedge clk) disable iff (rst) bfly_en_q |-> addr_b_q == addr_a_q + (LOG2N'(1) << stage_q));
    assert property (@(posedge clk) disable iff (rst) stage_q <= LAST_STAGE);
    assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
endmodule

// File: tb/tb_fft_stage_controller.sv
// tb_fft_stage_controller: randomized self-checking bench for fft_stage_controller.
//   A pass is modelled as a list of per-cycle items (issue / drain / done) built
//   from the address rule; stall and reset act on that list. A second instance
//   with BFLY_LAT=0 covers the no-drain configuration.
module tb_fft_stage_controller;
    localparam int N    = 8;
    localparam int LG   = 3;
    localparam int LAT  = 2;
    localparam int HALF = N / 2;

    typedef struct {
        int kind;
        int s;
        int k;
        int a;
        int b;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  stall_v = 1'b0;
    int    tests = 0;
    int    fails = 0;
    item_t q[$];
    bit    disp_en = 1'b0;
    int    last_a = 0;
    int    last_b = 0;
    int    ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int    eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

    always #5 clk = ~clk;

    fft_stage_controller_if #(.LOG2N(LG)) bus ();
    fft_stage_controller_if #(.LOG2N(LG)) bus0 ();
`ifdef FFT_STALL_EN
    assign bus.stall  = stall_v;
    assign bus0.stall = 1'b0;
`endif

    fft_stage_controller #(.N_POINTS(N), .LOG2N(LG), .BFLY_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    fft_stage_controller #(.N_POINTS(N), .LOG2N(LG), .BFLY_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lo_addr(input int s, input int k);
        return (k / (1 << s)) * (2 << s) + k % (1 << s);
    endfunction

    // kind: 0 = issue, 1 = drain, 2 = done
    task automatic build(input int lat);
        int la;
        q.delete();
        for (int s = 0; s < LG; s++) begin
            for (int k = 0; k < HALF; k++) q.push_back(item_t'{0, s, k, lo_addr(s, k), lo_addr(s, k) + (1 << s)});
            la = lo_addr(s, HALF - 1);
            for (int d = 0; d < lat; d++) q.push_back(item_t'{1, s, HALF - 1, la, la + (1 << s)});
        end
        la = lo_addr(LG - 1, HALF - 1);
        q.push_back(item_t'{2, LG - 1, HALF - 1, la, la + (1 << (LG - 1))});
    endtask

    task automatic model_edge(input bit st, input bit sl, input bit r);
        item_t cur;
        if (r) begin
            q.delete();
            last_a = 0;
            last_b = 0;
            disp_en = 1'b0;
            return;
        end
        if (q.size() == 0) begin
            if (st) begin
                build(LAT);
                disp_en = 1'b1;
            end
            return;
        end
        if (q[0].kind == 0 && !disp_en) begin
            disp_en = !sl;
            return;
        end
        cur = q.pop_front();
        if (q.size() == 0) begin
            last_a = cur.a;
            last_b = cur.b;
            disp_en = 1'b0;
            return;
        end
        disp_en = (q[0].kind == 0) && !(cur.kind == 0 && sl);
    endtask

    task automatic compare();
        if (q.size() == 0) begin
            check("idle_en", bus.bfly_en, 0);
            check("idle_stage", bus.stage_count_out, 0);
            check("idle_bfly", bus.bfly_count, 0);
            check("idle_addr_a", bus.addr_a, last_a);
            check("idle_addr_b", bus.addr_b, last_b);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
        end else begin
            check("en", bus.bfly_en, int'(q[0].kind == 0 && disp_en));
            check("stage", bus.stage_count_out, q[0].s);
            check("bfly", bus.bfly_count, q[0].k);
            check("addr_a", bus.addr_a, q[0].a);
            check("addr_b", bus.addr_b, q[0].b);
            check("busy", bus.busy, int'(q[0].kind != 2));
            check("done", bus.done, int'(q[0].kind == 2));
        end
    endtask

    task automatic cycle(input bit st, input bit st0, input bit sl, input bit r);
        @(negedge clk);
        bus.start = st;
        bus0.start = st0;
        stall_v = sl;
        rst = r;
        @(posedge clk);
        model_edge(st, sl, r);
        #1;
        compare();
    endtask

    function automatic bit rand_stall();
`ifdef FFT_STALL_EN
        return $urandom_range(0, 3) == 0;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int nbusy;
        int done_at;
        int nd;
        int got_a[$];
        int got_b[$];
        bus.start = 1'b0;
        bus0.start = 1'b0;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rst_busy0", bus0.busy, 0);
        repeat (3) cycle(0, 0, 0, 0);

        nbusy = 0;
        done_at = -1;
        nd = 0;
        for (int j = 0; j < 22; j++) begin
            cycle(j == 0 || j == 7 || j == 19, j == 0, 0, 0);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                done_at = j;
                nd++;
            end
            if (bus.bfly_en) begin
                got_a.push_back(int'(bus.addr_a));
                got_b.push_back(int'(bus.addr_b));
            end
            check("lat0_en", bus0.bfly_en, int'(j < 12));
            check("lat0_done", bus0.done, int'(j == 12));
            if (j < 12) begin
                check("lat0_addr_a", bus0.addr_a, ea[j]);
                check("lat0_addr_b", bus0.addr_b, eb[j]);
                check("lat0_stage", bus0.stage_count_out, j / 4);
            end
        end
        check("busy_cycles", nbusy, LG * (HALF + LAT));
        check("done_cycle", done_at, LG * (HALF + LAT));
        check("done_pulses", nd, 1);
        check("issue_count", got_a.size(), 12);
        for (int i = 0; i < got_a.size() && i < 12; i++) begin
            check("pair_a", got_a[i], ea[i]);
            check("pair_b", got_b[i], eb[i]);
        end

        cycle(1, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);
        check("pre_rst_stage", bus.stage_count_out, 1);
        check("pre_rst_bfly", bus.bfly_count, 2);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        nd = 0;
        repeat (25) begin
            cycle(0, 0, 0, 0);
            if (bus.done) nd++;
        end
        check("rst_no_done", nd, 0);

`ifdef FFT_STALL_EN
        done_at = -1;
        for (int j = 0; j < 24; j++) begin
            cycle(j == 0, 0, j == 1 || j == 2, 0);
            if (j == 1 || j == 2) check("stall_hold_en", bus.bfly_en, 0);
            if (j == 3) begin
                check("stall_issue_en", bus.bfly_en, 1);
                check("stall_issue_a", bus.addr_a, 2);
                check("stall_issue_b", bus.addr_b, 3);
            end
            if (bus.done) done_at = j;
        end
        check("stall_done_cycle", done_at, 20);
`endif

        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 5) == 0, 1'b0, rand_stall(), $urandom_range(0, 80) == 0);
        cycle(0, 0, 0, 1);
        repeat (40) cycle(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_stage_controller.md
Name: fft_stage_controller

Overview:
- Sequencing FSM for the radix-2 decimation-in-time (DIT) FFT core; sits directly upstream of twiddle_index.
- Drives stage_count_out, which twiddle_index consumes.
- Also issues butterfly enables and the sample-RAM read/write address pair for each butterfly.
- Steps through all log2(N) stages, inserting a drain gap after each stage so the butterfly pipeline clears before the next stage reads its results.

Parameters:
- N_POINTS, 8: FFT size; power of two, at least 4.
- LOG2N, 3: log2(N_POINTS); sets the stage_count_out width and the address width.
- BFLY_LAT, 2: butterfly pipeline latency in cycles, equal to the drain length; 0 is legal and means no drain.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request one full FFT pass; sampled only in IDLE.
- stall, in, 1: freeze issue; present only with FFT_STALL_EN.
- stage_count_out, out, LOG2N: current stage, 0..LOG2N-1; goes to twiddle_index.
- bfly_count, out, LOG2N-1: butterfly index within the stage, 0..N/2-1.
- bfly_en, out, 1: butterfly issued this cycle; addr_a and addr_b are valid.
- addr_a, out, LOG2N: top operand address.
- addr_b, out, LOG2N: bottom operand address.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse at the end of a pass.

Behaviour:
- All outputs are registered.
- Reset: on rst sampled high, the next state is IDLE and every output is 0. Reset outranks start and stall.
- Reset mid-pass: the pass aborts with no done pulse.
- States and transitions:
  - IDLE: go to ISSUE when start=1.
  - ISSUE: go to DRAIN after bfly_count==N/2-1 has issued. If BFLY_LAT==0, go straight to the next stage's ISSUE instead.
  - DRAIN: lasts exactly BFLY_LAT cycles; bfly_en=0.
  - After DRAIN: if stage_count_out<LOG2N-1, increment the stage, clear bfly_count and return to ISSUE. Otherwise go to DONE.
  - DONE: lasts one cycle (done=1, busy=0), then IDLE.
- Handshake timing: start high at edge t0 in IDLE gives, in cycle t0+1:
  - bfly_en=1, busy=1, stage 0, bfly 0.
- One butterfly issues per ISSUE cycle, with no bubbles unless stalled.
- busy is high in ISSUE and DRAIN.
- Total busy cycles = LOG2N*(N/2+BFLY_LAT); this is 18 at the defaults. done follows in the next cycle, i.e. cycle t0+19 at the defaults.
- start is ignored when the state is not IDLE, including in DONE. No queuing.
- Address rule, with s=stage and k=bfly_count:
  - addr_a = ((k>>s)<<(s+1)) | (k & ((1<<s)-1))
  - addr_b = addr_a + (1<<s)
  - All arithmetic is unsigned, LOG2N bits, and never wraps for legal k and s.
- In DRAIN and IDLE: stage_count_out holds its last value (0 in IDLE after reset or after DONE); addr_a, addr_b and bfly_count hold their values.
- stage_count_out changes only at a stage boundary, never in the middle of a stage.
- On leaving DONE, stage_count_out and bfly_count clear to 0.

Optional Feature:
- Macro: FFT_STALL_EN.
- Defined:
  - stall port exists.
  - stall=1 in ISSUE: bfly_en=0 that cycle; bfly_count, addresses and state hold; the held butterfly issues in the first cycle after stall falls.
  - stall in DRAIN, IDLE or DONE has no effect.
  - Each stalled ISSUE cycle extends busy by one cycle.
- Undefined: no stall port; issue is never interrupted.

Test Plan:
- Reset: hold rst for 2 cycles mid-pass (stage 1, bfly 2) -> next cycle all outputs 0, state IDLE, done never pulses.
- Default pass: start for 1 cycle, then check cycles t0+1..t0+4:
  - stage 0, (addr_a,addr_b) = (0,1),(2,3),(4,5),(6,7).
  - t0+5..6 bfly_en=0.
  - stage 1 pairs (0,2),(1,3),(4,6),(5,7).
  - stage 2 pairs (0,4),(1,5),(2,6),(3,7).
  - busy for exactly 18 cycles; done=1 only at t0+19.
- Twiddle hookup: connect to twiddle_index, run a pass -> stage_count_out reads 0,1,2 on stage boundaries only, never 3.
- Start ignored: pulse start at t0+7 and during DONE -> no restart, exactly one done pulse, IDLE at t0+20.
- BFLY_LAT=0 (N_POINTS=8) -> bfly_en continuous for 12 cycles; done at t0+13.
- With FFT_STALL_EN: stall high at t0+2..t0+3 -> addr (2,3) held and issued at t0+4; done at t0+21.
